// File: rtl/pps_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pps_pkg : shared widths, default phase modulus and FSM encoding
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package pps_pkg;
  localparam int PH_W       = 30;
  localparam int AVG_W      = 31;
  localparam int NCH        = 4;
  localparam int PH_MOD_DEF = 1000000000;

  localparam int         ST_W     = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;
endpackage
`default_nettype wire

// File: rtl/pps_phase_avg_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pps_phase_avg_ch : wrap-to-signed conversion, outlier compare and substitute
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module pps_phase_avg_ch
  import pps_pkg::*;
#(
  parameter int PH_MOD  = PH_MOD_DEF,
  parameter int REJ_THR = 1000
) (
  input  logic [PH_W-1:0]         i_ph,
  input  logic signed [AVG_W-1:0] i_avg,
  input  logic                    i_chk_en,
  output logic signed [AVG_W-1:0] o_smp,
  output logic                    o_rej
);
  localparam logic [PH_W-1:0]  c_MOD  = PH_W'(PH_MOD);
  localparam logic [PH_W-1:0]  c_HALF = PH_W'(PH_MOD / 2);
  localparam logic [AVG_W:0]   c_THR  = (AVG_W+1)'(REJ_THR);

  logic                    w_inv;
  logic                    w_far;
  logic signed [AVG_W-1:0] w_conv;
  logic signed [AVG_W:0]   w_diff;
  logic [AVG_W:0]          w_mag;

  always_comb begin
    w_inv = (i_ph >= c_MOD);
    if (i_ph < c_HALF) begin
      w_conv = {1'b0, i_ph};
    end else begin
      w_conv = {1'b0, i_ph} - {1'b0, c_MOD};
    end
    // One extra bit so the difference of two in-range values cannot wrap
    w_diff = {w_conv[AVG_W-1], w_conv} - {i_avg[AVG_W-1], i_avg};
    w_mag  = w_diff[AVG_W] ? -w_diff : w_diff;
    w_far  = (w_mag > c_THR);
    o_rej  = w_inv | (i_chk_en & w_far);
    if (o_rej) begin
      o_smp = i_chk_en ? i_avg : '0;
    end else begin
      o_smp = w_conv;
    end
  end
endmodule
`default_nettype wire

// File: rtl/pps_phase_avg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pps_phase_avg : per-channel PPS phase boxcar average with outlier rejection
// Optional: PPS_PHASE_AVG_MINMAX_EN adds per-window min/max outputs
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module pps_phase_avg
  import pps_pkg::*;
#(
  parameter int AVG_LOG2 = 4,
  parameter int PH_MOD   = PH_MOD_DEF,
  parameter int REJ_THR  = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ph_en,
  input  logic [PH_W-1:0]   i_ph1,
  input  logic [PH_W-1:0]   i_ph2,
  input  logic [PH_W-1:0]   i_ph3,
  input  logic [PH_W-1:0]   i_ph4,
  output logic              o_avg_en,
  output logic [AVG_W-1:0]  o_avg1,
  output logic [AVG_W-1:0]  o_avg2,
  output logic [AVG_W-1:0]  o_avg3,
  output logic [AVG_W-1:0]  o_avg4,
  output logic [NCH-1:0]    o_rej_mask,
`ifdef PPS_PHASE_AVG_MINMAX_EN
  output logic [AVG_W-1:0]  o_min1,
  output logic [AVG_W-1:0]  o_min2,
  output logic [AVG_W-1:0]  o_min3,
  output logic [AVG_W-1:0]  o_min4,
  output logic [AVG_W-1:0]  o_max1,
  output logic [AVG_W-1:0]  o_max2,
  output logic [AVG_W-1:0]  o_max3,
  output logic [AVG_W-1:0]  o_max4,
`endif
  output logic              o_drop
);
  localparam int                c_ACC_W  = AVG_W + AVG_LOG2;
  localparam int                c_EP_W   = 9;
  localparam logic [c_EP_W-1:0] c_WIN_EP = c_EP_W'(1 << AVG_LOG2);

  logic [ST_W-1:0]           r_state;
  logic [1:0]                r_idx;
  logic [PH_W-1:0]           r_hold [NCH];
  logic signed [c_ACC_W-1:0] r_acc  [NCH];
  logic signed [AVG_W-1:0]   r_avg  [NCH];
  logic [NCH-1:0]            r_pend;
  logic [NCH-1:0]            r_rej_mask;
  logic [c_EP_W-1:0]         r_epoch;
  logic                      r_first_done;
  logic                      r_avg_en;

  logic signed [AVG_W-1:0]   w_smp;
  logic                      w_rej;
  logic signed [AVG_W-1:0]   w_avg_nxt [NCH];

  pps_phase_avg_ch #(
    .PH_MOD  (PH_MOD),
    .REJ_THR (REJ_THR)
  ) u_ch (
    .i_ph     (r_hold[r_idx]),
    .i_avg    (r_avg[r_idx]),
    .i_chk_en (r_first_done),
    .o_smp    (w_smp),
    .o_rej    (w_rej)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_avg
    assign w_avg_nxt[g] = AVG_W'(r_acc[g] >>> AVG_LOG2);
  end

`ifdef PPS_PHASE_AVG_MINMAX_EN
  logic signed [AVG_W-1:0] r_trk_min [NCH];
  logic signed [AVG_W-1:0] r_trk_max [NCH];
  logic signed [AVG_W-1:0] r_min     [NCH];
  logic signed [AVG_W-1:0] r_max     [NCH];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_pend       <= '0;
      r_rej_mask   <= '0;
      r_epoch      <= '0;
      r_first_done <= 1'b0;
      r_avg_en     <= 1'b0;
      for (int n = 0; n < NCH; n++) begin
        r_hold[n] <= '0;
        r_acc[n]  <= '0;
        r_avg[n]  <= '0;
`ifdef PPS_PHASE_AVG_MINMAX_EN
        r_trk_min[n] <= '0;
        r_trk_max[n] <= '0;
        r_min[n]     <= '0;
        r_max[n]     <= '0;
`endif
      end
    end else begin
      r_avg_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_ph_en) begin
            r_hold[0] <= i_ph1;
            r_hold[1] <= i_ph2;
            r_hold[2] <= i_ph3;
            r_hold[3] <= i_ph4;
            r_idx     <= '0;
            r_state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_acc[r_idx]  <= r_acc[r_idx] + c_ACC_W'(w_smp);
          r_pend[r_idx] <= r_pend[r_idx] | w_rej;
`ifdef PPS_PHASE_AVG_MINMAX_EN
          if ((r_epoch == '0) || (w_smp < r_trk_min[r_idx])) r_trk_min[r_idx] <= w_smp;
          if ((r_epoch == '0) || (w_smp > r_trk_max[r_idx])) r_trk_max[r_idx] <= w_smp;
`endif
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          // Window closes here so o_avg_en lands in the OUT cycle
          if ((r_epoch + c_EP_W'(1)) == c_WIN_EP) begin
            for (int n = 0; n < NCH; n++) begin
              r_avg[n] <= w_avg_nxt[n];
              r_acc[n] <= '0;
`ifdef PPS_PHASE_AVG_MINMAX_EN
              r_min[n] <= r_trk_min[n];
              r_max[n] <= r_trk_max[n];
`endif
            end
            r_rej_mask   <= r_pend;
            r_pend       <= '0;
            r_epoch      <= '0;
            r_first_done <= 1'b1;
            r_avg_en     <= 1'b1;
            r_state      <= ST_OUT;
          end else begin
            r_epoch <= r_epoch + c_EP_W'(1);
            r_state <= ST_IDLE;
          end
        end
        ST_OUT:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_avg_en   = r_avg_en;
  assign o_avg1     = r_avg[0];
  assign o_avg2     = r_avg[1];
  assign o_avg3     = r_avg[2];
  assign o_avg4     = r_avg[3];
  assign o_rej_mask = r_rej_mask;
  assign o_drop     = i_ph_en & (r_state != ST_IDLE);

`ifdef PPS_PHASE_AVG_MINMAX_EN
  assign o_min1 = r_min[0];
  assign o_min2 = r_min[1];
  assign o_min3 = r_min[2];
  assign o_min4 = r_min[3];
  assign o_max1 = r_max[0];
  assign o_max2 = r_max[1];
  assign o_max3 = r_max[2];
  assign o_max4 = r_max[3];
`endif
endmodule
`default_nettype wire
